// File: rtl/ysyx_22050243_mc_ctrl.sv
// Multi-cycle core control FSM: fetch, decode, execute, memory, writeback, with
// bus-response timeout and illegal-opcode trapping. All strobes are Moore outputs.
module ysyx_22050243_mc_ctrl #(
    parameter int unsigned IBUS_DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT         = 255
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       ifu_req_valid,
    input  logic                       ifu_req_ready,
    input  logic                       ifu_rsp_valid,
    input  logic [IBUS_DATA_WIDTH-1:0] ifu_rsp_inst,
    output logic [IBUS_DATA_WIDTH-1:0] inst_o,
    output logic [2:0]                 imm_sel,
    output logic                       lsu_req_valid,
    input  logic                       lsu_req_ready,
    output logic                       lsu_req_we,
    input  logic                       lsu_rsp_valid,
    output logic                       rf_we,
    output logic                       pc_we,
    output logic                       illegal_o,
    output logic                       bus_err_o,
    output logic [3:0]                 state_o,
    output logic [63:0]                minstret_o
);

    typedef enum logic [3:0] {
        StIdle, StFetchReq, StFetchWait, StDecode, StExecute,
        StMemReq, StMemWait, StWriteback, StTrap
    } state_e;

    localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    // Last absent-response cycle before the count would reach TIMEOUT.
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT - 1);

    localparam logic [6:0] OpOp     = 7'b0110011;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpImm32  = 7'b0011011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;

    state_e                     state_q, state_d;
    logic [IBUS_DATA_WIDTH-1:0] inst_q, inst_d;
    logic [CntW-1:0]            cnt_q, cnt_d;
    logic [63:0]                minstret_q, minstret_d;
    logic                       illegal_q, illegal_d;
    logic                       bus_err_q, bus_err_d;

    logic [6:0] opcode;
    logic [2:0] dec_cls;
    logic       dec_legal;
    logic       is_store, is_mem, in_inst;

    assign opcode   = inst_q[6:0];
    assign is_store = (opcode == OpStore);
    assign is_mem   = is_store || (opcode == OpLoad);

    always_comb begin
        dec_cls   = 3'd0;
        dec_legal = 1'b1;
        case (opcode)
            OpOp:                             dec_cls = 3'd0;
            OpJalr, OpLoad, OpImm, OpImm32:   dec_cls = 3'd1;
            OpStore:                          dec_cls = 3'd2;
            OpBranch:                         dec_cls = 3'd3;
            OpLui, OpAuipc:                   dec_cls = 3'd4;
            OpJal:                            dec_cls = 3'd5;
            default:                          dec_legal = 1'b0;
        endcase
    end

    // inst_q is frozen from DECODE through WRITEBACK, so the class stays stable.
    assign in_inst = (state_q == StDecode) || (state_q == StExecute) || (state_q == StMemReq) ||
                     (state_q == StMemWait) || (state_q == StWriteback);

    always_comb begin
        state_d    = state_q;
        inst_d     = inst_q;
        cnt_d      = cnt_q;
        minstret_d = minstret_q;
        illegal_d  = illegal_q;
        bus_err_d  = bus_err_q;
        case (state_q)
            StIdle:     state_d = StFetchReq;
            StFetchReq: begin
                if (ifu_req_ready) begin
                    state_d = StFetchWait;
                    cnt_d   = '0;
                end
            end
            StFetchWait: begin
                if (ifu_rsp_valid) begin
                    inst_d  = ifu_rsp_inst;
                    state_d = StDecode;
                end else if (cnt_q == CntMax) begin
                    state_d   = StTrap;
                    bus_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDecode: begin
                if (dec_legal) begin
                    state_d = StExecute;
                end else begin
                    state_d   = StTrap;
                    illegal_d = 1'b1;
                end
            end
            StExecute:  state_d = is_mem ? StMemReq : StWriteback;
            StMemReq: begin
                if (lsu_req_ready) begin
                    state_d = StMemWait;
                    cnt_d   = '0;
                end
            end
            StMemWait: begin
                if (lsu_rsp_valid) begin
                    state_d = StWriteback;
                end else if (cnt_q == CntMax) begin
                    state_d   = StTrap;
                    bus_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StWriteback: begin
                minstret_d = minstret_q + 64'd1;
                state_d    = StFetchReq;
            end
            StTrap:     state_d = StTrap;
            default:    state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            inst_q     <= '0;
            cnt_q      <= '0;
            minstret_q <= '0;
            illegal_q  <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            inst_q     <= inst_d;
            cnt_q      <= cnt_d;
            minstret_q <= minstret_d;
            illegal_q  <= illegal_d;
            bus_err_q  <= bus_err_d;
        end
    end

    assign ifu_req_valid = (state_q == StFetchReq);
    assign lsu_req_valid = (state_q == StMemReq);
    assign lsu_req_we    = (state_q == StMemReq) && is_store;
    assign pc_we         = (state_q == StWriteback);
    assign rf_we         = (state_q == StWriteback) && !is_store && (opcode != OpBranch) &&
                           (inst_q[11:7] != 5'd0);
    assign imm_sel       = in_inst ? dec_cls : 3'd0;
    assign inst_o        = inst_q;
    assign illegal_o     = illegal_q;
    assign bus_err_o     = bus_err_q;
    assign state_o       = state_q;
    assign minstret_o    = minstret_q;

endmodule

// File: tb/tb_ysyx_22050243_mc_ctrl.sv
// Directed bench for ysyx_22050243_mc_ctrl: a per-cycle vector table plus
// hand-written sequences for decode classes, reset, trap and timeout behaviour.
module tb_ysyx_22050243_mc_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid;
    logic [31:0] ifu_rsp_inst, inst_o;
    logic [2:0]  imm_sel;
    logic        lsu_req_valid, lsu_req_ready, lsu_req_we, lsu_rsp_valid;
    logic        rf_we, pc_we, illegal_o, bus_err_o;
    logic [3:0]  state_o;
    logic [63:0] minstret_o;

    int n_cmp = 0;
    int n_bad = 0;
    logic [63:0] exp_mi;

    always #5 clk = ~clk;

    ysyx_22050243_mc_ctrl #(
        .IBUS_DATA_WIDTH(32),
        .TIMEOUT        (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ifu_req_valid(ifu_req_valid),
        .ifu_req_ready(ifu_req_ready),
        .ifu_rsp_valid(ifu_rsp_valid),
        .ifu_rsp_inst (ifu_rsp_inst),
        .inst_o       (inst_o),
        .imm_sel      (imm_sel),
        .lsu_req_valid(lsu_req_valid),
        .lsu_req_ready(lsu_req_ready),
        .lsu_req_we   (lsu_req_we),
        .lsu_rsp_valid(lsu_rsp_valid),
        .rf_we        (rf_we),
        .pc_we        (pc_we),
        .illegal_o    (illegal_o),
        .bus_err_o    (bus_err_o),
        .state_o      (state_o),
        .minstret_o   (minstret_o)
    );

    typedef struct {
        logic        irdy, irsp;
        logic [31:0] inst;
        logic        lrdy, lrsp;
        logic [3:0]  st;
        logic        ireq, lreq, lwe, rfwe, pcwe;
        logic [2:0]  imm;
        logic [63:0] mi;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t v(input logic irdy, input logic irsp, input logic [31:0] inst,
                               input logic lrdy, input logic lrsp, input logic [3:0] st,
                               input logic ireq, input logic lreq, input logic lwe,
                               input logic rfwe, input logic pcwe, input logic [2:0] imm,
                               input logic [63:0] mi);
        vec_t r;
        r.irdy = irdy; r.irsp = irsp; r.inst = inst; r.lrdy = lrdy; r.lrsp = lrsp;
        r.st = st; r.ireq = ireq; r.lreq = lreq; r.lwe = lwe; r.rfwe = rfwe;
        r.pcwe = pcwe; r.imm = imm; r.mi = mi;
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ifu_req_ready = 1'b0;
        ifu_rsp_valid = 1'b0;
        ifu_rsp_inst  = 32'h0;
        lsu_req_ready = 1'b0;
        lsu_rsp_valid = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        exp_mi = 64'd0;
    endtask

    // From IDLE: one cycle to FETCH_REQ, one accepted request into FETCH_WAIT.
    task automatic to_fetch_wait();
        step();
        ifu_req_ready = 1'b1;
        step();
        ifu_req_ready = 1'b0;
    endtask

    // Runs one instruction from FETCH_REQ with immediate bus responses.
    task automatic run_inst(input logic [31:0] inst, input logic [2:0] imm,
                            input logic rf, input logic we);
        string tag;
        tag = $sformatf("inst %08h", inst);
        ifu_req_ready = 1'b1;
        step();
        ifu_req_ready = 1'b0;
        ifu_rsp_valid = 1'b1;
        ifu_rsp_inst  = inst;
        step();
        ifu_rsp_valid = 1'b0;
        check({tag, " decode state"}, state_o, 4'd3);
        check({tag, " decode imm_sel"}, imm_sel, imm);
        lsu_req_ready = 1'b1;
        lsu_rsp_valid = 1'b1;
        for (int i = 0; i < 10 && state_o != 4'd7; i++) begin
            if (state_o == 4'd5) check({tag, " lsu_req_we"}, lsu_req_we, we);
            step();
        end
        lsu_req_ready = 1'b0;
        lsu_rsp_valid = 1'b0;
        check({tag, " wb state"}, state_o, 4'd7);
        check({tag, " wb rf_we"}, rf_we, rf);
        check({tag, " wb pc_we"}, pc_we, 1'b1);
        check({tag, " wb imm_sel"}, imm_sel, imm);
        step();
        exp_mi = exp_mi + 64'd1;
        check({tag, " minstret"}, minstret_o, exp_mi);
        check({tag, " next state"}, state_o, 4'd1);
    endtask

    initial begin
        clear_inputs();
        // irdy irsp inst lrdy lrsp | st ireq lreq lwe rf pc imm mi
        vq.push_back(v(0, 0, 32'h0,        0, 0, 4'd0, 0, 0, 0, 0, 0, 3'd0, 64'd0));
        vq.push_back(v(1, 0, 32'h0,        0, 0, 4'd1, 1, 0, 0, 0, 0, 3'd0, 64'd0));
        vq.push_back(v(0, 1, 32'h00500093, 0, 0, 4'd2, 0, 0, 0, 0, 0, 3'd0, 64'd0));
        vq.push_back(v(0, 0, 32'h0,        0, 0, 4'd3, 0, 0, 0, 0, 0, 3'd1, 64'd0));
        vq.push_back(v(0, 0, 32'h0,        0, 0, 4'd4, 0, 0, 0, 0, 0, 3'd1, 64'd0));
        vq.push_back(v(0, 0, 32'h0,        0, 0, 4'd7, 0, 0, 0, 1, 1, 3'd1, 64'd0));
        vq.push_back(v(1, 0, 32'h0,        0, 0, 4'd1, 1, 0, 0, 0, 0, 3'd0, 64'd1));
        vq.push_back(v(0, 1, 32'h00112023, 0, 0, 4'd2, 0, 0, 0, 0, 0, 3'd0, 64'd1));
        vq.push_back(v(0, 0, 32'h0,        0, 0, 4'd3, 0, 0, 0, 0, 0, 3'd2, 64'd1));
        vq.push_back(v(0, 0, 32'h0,        0, 0, 4'd4, 0, 0, 0, 0, 0, 3'd2, 64'd1));
        vq.push_back(v(0, 0, 32'h0,        0, 0, 4'd5, 0, 1, 1, 0, 0, 3'd2, 64'd1));
        vq.push_back(v(0, 0, 32'h0,        0, 0, 4'd5, 0, 1, 1, 0, 0, 3'd2, 64'd1));
        vq.push_back(v(0, 0, 32'h0,        0, 0, 4'd5, 0, 1, 1, 0, 0, 3'd2, 64'd1));
        vq.push_back(v(0, 0, 32'h0,        1, 0, 4'd5, 0, 1, 1, 0, 0, 3'd2, 64'd1));
        vq.push_back(v(0, 0, 32'h0,        0, 1, 4'd6, 0, 0, 0, 0, 0, 3'd2, 64'd1));
        vq.push_back(v(0, 0, 32'h0,        0, 0, 4'd7, 0, 0, 0, 0, 1, 3'd2, 64'd1));
        vq.push_back(v(1, 0, 32'h0,        0, 0, 4'd1, 1, 0, 0, 0, 0, 3'd0, 64'd2));
        vq.push_back(v(0, 1, 32'h00100013, 0, 0, 4'd2, 0, 0, 0, 0, 0, 3'd0, 64'd2));
        vq.push_back(v(0, 0, 32'h0,        0, 0, 4'd3, 0, 0, 0, 0, 0, 3'd1, 64'd2));
        vq.push_back(v(0, 0, 32'h0,        0, 0, 4'd4, 0, 0, 0, 0, 0, 3'd1, 64'd2));
        vq.push_back(v(0, 0, 32'h0,        0, 0, 4'd7, 0, 0, 0, 0, 1, 3'd1, 64'd2));
        vq.push_back(v(0, 0, 32'h0,        0, 0, 4'd1, 1, 0, 0, 0, 0, 3'd0, 64'd3));

        do_reset();
        check("reset inst_o", inst_o, 32'h0);
        check("reset illegal_o", illegal_o, 1'b0);
        check("reset bus_err_o", bus_err_o, 1'b0);

        foreach (vq[i]) begin
            string r;
            r = $sformatf("row%0d", i);
            check({r, " state"}, state_o, vq[i].st);
            check({r, " ifu_req_valid"}, ifu_req_valid, vq[i].ireq);
            check({r, " lsu_req_valid"}, lsu_req_valid, vq[i].lreq);
            check({r, " lsu_req_we"}, lsu_req_we, vq[i].lwe);
            check({r, " rf_we"}, rf_we, vq[i].rfwe);
            check({r, " pc_we"}, pc_we, vq[i].pcwe);
            check({r, " imm_sel"}, imm_sel, vq[i].imm);
            check({r, " minstret"}, minstret_o, vq[i].mi);
            ifu_req_ready = vq[i].irdy;
            ifu_rsp_valid = vq[i].irsp;
            ifu_rsp_inst  = vq[i].inst;
            lsu_req_ready = vq[i].lrdy;
            lsu_rsp_valid = vq[i].lrsp;
            if (i != vq.size() - 1) step();
        end
        clear_inputs();
        check("table inst_o", inst_o, 32'h00100013);

        // Remaining decode classes, continuing from FETCH_REQ.
        exp_mi = 64'd3;
        run_inst(32'h00002083, 3'd1, 1'b1, 1'b0);  // lw x1,0(x0)
        run_inst(32'h00000f63, 3'd3, 1'b0, 1'b0);  // branch, rd field nonzero
        run_inst(32'h000012b7, 3'd4, 1'b1, 1'b0);  // lui x5
        run_inst(32'h00000097, 3'd4, 1'b1, 1'b0);  // auipc x1
        run_inst(32'h000000ef, 3'd5, 1'b1, 1'b0);  // jal x1
        run_inst(32'h000080e7, 3'd1, 1'b1, 1'b0);  // jalr x1
        run_inst(32'h002081b3, 3'd0, 1'b1, 1'b0);  // add x3,x1,x2
        run_inst(32'h0000009b, 3'd1, 1'b1, 1'b0);  // addiw x1
        run_inst(32'h00112023, 3'd2, 1'b0, 1'b1);  // sw

        // Reset asserted while a load waits for its memory response.
        ifu_req_ready = 1'b1;
        step();
        ifu_req_ready = 1'b0;
        ifu_rsp_valid = 1'b1;
        ifu_rsp_inst  = 32'h00002083;
        step();
        ifu_rsp_valid = 1'b0;
        step();
        step();
        lsu_req_ready = 1'b1;
        step();
        lsu_req_ready = 1'b0;
        check("pre-reset state", state_o, 4'd6);
        #2;
        rst = 1'b1;
        #1;
        check("async rst state", state_o, 4'd0);
        check("async rst inst_o", inst_o, 32'h0);
        check("async rst minstret", minstret_o, 64'd0);
        check("async rst strobes",
              {ifu_req_valid, lsu_req_valid, lsu_req_we, rf_we, pc_we, imm_sel}, 8'h0);
        step();
        rst = 1'b0;
        lsu_rsp_valid = 1'b1;
        check("post-rst state", state_o, 4'd0);
        step();
        check("post-rst fetch state", state_o, 4'd1);
        check("post-rst lsu_req_valid", lsu_req_valid, 1'b0);
        lsu_rsp_valid = 1'b0;

        // Illegal opcode traps and stops fetching.
        do_reset();
        to_fetch_wait();
        ifu_rsp_valid = 1'b1;
        ifu_rsp_inst  = 32'h00000000;
        step();
        ifu_rsp_valid = 1'b0;
        check("illegal decode state", state_o, 4'd3);
        step();
        check("illegal trap state", state_o, 4'd8);
        check("illegal_o", illegal_o, 1'b1);
        check("illegal bus_err_o", bus_err_o, 1'b0);
        ifu_req_ready = 1'b1;
        ifu_rsp_valid = 1'b1;
        lsu_req_ready = 1'b1;
        lsu_rsp_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            check($sformatf("trap cyc%0d outputs", i),
                  {state_o, ifu_req_valid, lsu_req_valid, rf_we, pc_we, illegal_o},
                  {4'd8, 4'b0000, 1'b1});
            step();
        end
        clear_inputs();

        // Fetch timeout with no response.
        do_reset();
        to_fetch_wait();
        check("timeout wait state", state_o, 4'd2);
        repeat (3) step();
        check("timeout still waiting", state_o, 4'd2);
        step();
        check("timeout trap state", state_o, 4'd8);
        check("timeout bus_err_o", bus_err_o, 1'b1);
        check("timeout illegal_o", illegal_o, 1'b0);

        // Response in the timeout cycle wins.
        do_reset();
        check("reset clears bus_err_o", bus_err_o, 1'b0);
        to_fetch_wait();
        repeat (3) step();
        ifu_rsp_valid = 1'b1;
        ifu_rsp_inst  = 32'h00500093;
        step();
        ifu_rsp_valid = 1'b0;
        check("late rsp state", state_o, 4'd3);
        check("late rsp bus_err_o", bus_err_o, 1'b0);
        step();
        check("late rsp execute", state_o, 4'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
